iiitb_4bbc_sweep_ctrl: RTL and testbench

IIITB_4BBC_SWEEP_CTRL -- requirements
Module: iiitb_4bbc_sweep_ctrl

---
 rtl/iiitb_4bbc_sweep_ctrl.sv | 150 +++++++++++++++
 tb/tb_iiitb_4bbc_sweep_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_4bbc_sweep_ctrl.sv
// Up/down sweep controller: counts lo..hi..lo for a number of round trips, DWELL cycles per step.
// Optional build macro SWEEP_PAUSE_EN adds a 'pause' input that freezes an active sweep.
module iiitb_4bbc_sweep_ctrl #(
    parameter int unsigned DWELL = 1   // legal range 1..16
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] lo_lim,
    input  logic [3:0] hi_lim,
    input  logic [3:0] passes,
    input  logic       abort,
`ifdef SWEEP_PAUSE_EN
    input  logic       pause,
`endif
    output logic [3:0] Count,
    output logic       UpOrDown,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] pass_cnt
);

    typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

    localparam logic [3:0] STEP_AT = 4'(DWELL - 1);

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       dir_q, dir_d;
    logic [3:0] pcnt_q, pcnt_d;
    logic [3:0] presc_q, presc_d;
    logic [3:0] lo_q, lo_d;
    logic [3:0] hi_q, hi_d;
    logic [3:0] passes_q, passes_d;
    logic       err_q, err_d;
    logic       hold;
    logic       step;
    logic [3:0] pcnt_inc;

`ifdef SWEEP_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign step     = (presc_q == STEP_AT);
    assign pcnt_inc = pcnt_q + 4'd1;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            dir_q    <= 1'b1;
            pcnt_q   <= '0;
            presc_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            passes_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            pcnt_q   <= pcnt_d;
            presc_q  <= presc_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            passes_q <= passes_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        dir_d    = dir_q;
        pcnt_d   = pcnt_q;
        presc_d  = presc_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        passes_d = passes_q;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // abort outranks start; a rejected start only raises err
                if (start && !abort) begin
                    if (lo_lim < hi_lim) begin
                        lo_d     = lo_lim;
                        hi_d     = hi_lim;
                        passes_d = (passes == 4'd0) ? 4'd1 : passes;
                        count_d  = lo_lim;
                        pcnt_d   = '0;
                        presc_d  = '0;
                        dir_d    = 1'b1;
                        state_d  = UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            UP, DOWN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    if (!step) begin
                        presc_d = presc_q + 4'd1;
                    end else begin
                        presc_d = '0;
                        if (state_q == UP) begin
                            if (count_q < hi_q) begin
                                count_d = count_q + 4'd1;
                            end else begin
                                count_d = hi_q - 4'd1;
                                dir_d   = 1'b0;
                                state_d = DOWN;
                            end
                        end else if (count_q > lo_q) begin
                            count_d = count_q - 4'd1;
                        end else begin
                            // reaching lo closes a round trip; Count stays at lo on the final one
                            pcnt_d = pcnt_inc;
                            if (pcnt_inc == passes_q) begin
                                state_d = DONE;
                            end else begin
                                count_d = lo_q + 4'd1;
                                dir_d   = 1'b1;
                                state_d = UP;
                            end
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Count    = count_q;
    assign UpOrDown = dir_q;
    assign busy     = (state_q == UP) || (state_q == DOWN);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign pass_cnt = pcnt_q;

endmodule

// File: tb/tb_iiitb_4bbc_sweep_ctrl.sv
// Bench for iiitb_4bbc_sweep_ctrl: DWELL=1 and DWELL=3 instances checked against a queue-based sweep model.
module tb_iiitb_4bbc_sweep_ctrl;

    typedef struct {
        logic [3:0] c;
        logic       dir;
        logic [3:0] p;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] lo_lim, hi_lim, passes;
    logic       start_v [2];
    logic       abort_v [2];
    logic [3:0] cnt_o   [2];
    logic       dir_o   [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       err_o   [2];
    logic [3:0] pc_o    [2];
`ifdef SWEEP_PAUSE_EN
    logic       pause_v [2];
`endif

    int tests = 0;
    int fails = 0;

    exp_t       exp_q[$];
    logic [3:0] hc [2];
    logic [3:0] hp [2];
    logic       hd [2];

    iiitb_4bbc_sweep_ctrl #(.DWELL(1)) u_d1 (
        .Clk(clk), .reset(reset), .start(start_v[0]),
        .lo_lim(lo_lim), .hi_lim(hi_lim), .passes(passes), .abort(abort_v[0]),
`ifdef SWEEP_PAUSE_EN
        .pause(pause_v[0]),
`endif
        .Count(cnt_o[0]), .UpOrDown(dir_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .err(err_o[0]), .pass_cnt(pc_o[0])
    );

    iiitb_4bbc_sweep_ctrl #(.DWELL(3)) u_d3 (
        .Clk(clk), .reset(reset), .start(start_v[1]),
        .lo_lim(lo_lim), .hi_lim(hi_lim), .passes(passes), .abort(abort_v[1]),
`ifdef SWEEP_PAUSE_EN
        .pause(pause_v[1]),
`endif
        .Count(cnt_o[1]), .UpOrDown(dir_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .err(err_o[1]), .pass_cnt(pc_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Expected per-cycle trajectory of an active sweep, straight from the stepping rules.
    task automatic build_exp(input int dw, input int lo, input int hi, input int np);
        exp_q.delete();
        for (int p = 0; p < np; p++) begin
            for (int v = (p == 0) ? lo : lo + 1; v <= hi; v++)
                for (int k = 0; k < dw; k++) exp_q.push_back('{4'(v), 1'b1, 4'(p)});
            for (int v = hi - 1; v >= lo; v--)
                for (int k = 0; k < dw; k++) exp_q.push_back('{4'(v), 1'b0, 4'(p)});
        end
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, "_busy"},  32'(busy_o[d]), 32'd0);
        chk({tag, "_done"},  32'(done_o[d]), 32'd0);
        chk({tag, "_count"}, 32'(cnt_o[d]),  32'(hc[d]));
        chk({tag, "_pcnt"},  32'(pc_o[d]),   32'(hp[d]));
        chk({tag, "_dir"},   32'(dir_o[d]),  32'(hd[d]));
    endtask

    // Runs one accepted sweep from a negedge; optional abort at entry abort_at,
    // optional 4-cycle pause at entry pause_at, optional input noise on limits/start.
    task automatic sweep(input int d, input logic [3:0] lo, input logic [3:0] hi,
                         input logic [3:0] ps, input int abort_at, input int pause_at,
                         input bit noise);
        int np;
        np = (ps == 4'd0) ? 1 : int'(ps);
        build_exp((d == 1) ? 3 : 1, int'(lo), int'(hi), np);
        lo_lim = lo; hi_lim = hi; passes = ps; start_v[d] = 1'b1;
        @(posedge clk); @(negedge clk);
        start_v[d] = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            chk("sw_busy",  32'(busy_o[d]), 32'd1);
            chk("sw_done",  32'(done_o[d]), 32'd0);
            chk("sw_count", 32'(cnt_o[d]),  32'(exp_q[i].c));
            chk("sw_dir",   32'(dir_o[d]),  32'(exp_q[i].dir));
            chk("sw_pcnt",  32'(pc_o[d]),   32'(exp_q[i].p));
`ifdef SWEEP_PAUSE_EN
            if (i == pause_at) begin
                pause_v[d] = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("pause_count", 32'(cnt_o[d]),  32'(exp_q[i].c));
                    chk("pause_busy",  32'(busy_o[d]), 32'd1);
                end
                pause_v[d] = 1'b0;
            end
`endif
            if (i == abort_at) begin
                start_v[d] = 1'b0;
                abort_v[d] = 1'b1;
                @(posedge clk); @(negedge clk);
                abort_v[d] = 1'b0;
                hc[d] = exp_q[i].c; hp[d] = exp_q[i].p; hd[d] = exp_q[i].dir;
                chk_idle(d, "abort");
                @(negedge clk);
                chk_idle(d, "abort_after");
                return;
            end
            if (noise) begin
                lo_lim = 4'($urandom); hi_lim = 4'($urandom); passes = 4'($urandom);
                start_v[d] = 1'($urandom);
            end
            @(negedge clk);
        end
        start_v[d] = 1'b0;
        chk("fin_done",  32'(done_o[d]), 32'd1);
        chk("fin_busy",  32'(busy_o[d]), 32'd0);
        chk("fin_count", 32'(cnt_o[d]),  32'(lo));
        chk("fin_pcnt",  32'(pc_o[d]),   32'(np));
        hc[d] = lo; hp[d] = 4'(np); hd[d] = 1'b0;
        @(negedge clk);
        chk_idle(d, "post_done");
        chk("post_done_err", 32'(err_o[d]), 32'd0);
    endtask

    task automatic bad_start(input int d, input logic [3:0] lo, input logic [3:0] hi);
        lo_lim = lo; hi_lim = hi; passes = 4'd1; start_v[d] = 1'b1;
        @(posedge clk); @(negedge clk);
        start_v[d] = 1'b0;
        chk("bad_err", 32'(err_o[d]), 32'd1);
        chk_idle(d, "bad");
        @(negedge clk);
        chk("bad_err_clr", 32'(err_o[d]), 32'd0);
        chk_idle(d, "bad_after");
    endtask

    task automatic start_abort(input int d);
        lo_lim = 4'd1; hi_lim = 4'd8; passes = 4'd1;
        start_v[d] = 1'b1; abort_v[d] = 1'b1;
        @(posedge clk); @(negedge clk);
        start_v[d] = 1'b0; abort_v[d] = 1'b0;
        chk("sa_err", 32'(err_o[d]), 32'd0);
        chk_idle(d, "sa");
        @(negedge clk);
        chk_idle(d, "sa_after");
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_count"}, 32'(cnt_o[d]),  32'd0);
            chk({tag, "_dir"},   32'(dir_o[d]),  32'd1);
            chk({tag, "_busy"},  32'(busy_o[d]), 32'd0);
            chk({tag, "_done"},  32'(done_o[d]), 32'd0);
            chk({tag, "_err"},   32'(err_o[d]),  32'd0);
            chk({tag, "_pcnt"},  32'(pc_o[d]),   32'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, lo, hi, ps, ab;
        reset = 1'b0;
        lo_lim = '0; hi_lim = '0; passes = '0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; abort_v[i] = 1'b0;
            hc[i] = '0; hp[i] = '0; hd[i] = 1'b1;
`ifdef SWEEP_PAUSE_EN
            pause_v[i] = 1'b0;
`endif
        end
        @(negedge clk); @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b1;
        @(negedge clk);

        sweep(0, 4'd2, 4'd5, 4'd1, -1, -1, 1'b0);
        bad_start(0, 4'd7, 4'd7);
        bad_start(0, 4'd9, 4'd3);
        sweep(0, 4'd0, 4'd15, 4'd2, -1, -1, 1'b1);
        sweep(0, 4'd2, 4'd6, 4'd1, 2, -1, 1'b0);
        sweep(0, 4'd2, 4'd6, 4'd1, -1, -1, 1'b0);
        sweep(1, 4'd1, 4'd2, 4'd0, -1, -1, 1'b0);
        bad_start(1, 4'd5, 4'd5);
        start_abort(0);
        start_abort(1);

        // reset asserted away from any clock edge must clear outputs at once
        lo_lim = 4'd3; hi_lim = 4'd9; passes = 4'd2;
        start_v[0] = 1'b1; start_v[1] = 1'b1;
        @(posedge clk); @(negedge clk);
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin hc[i] = '0; hp[i] = '0; hd[i] = 1'b1; end
        @(negedge clk);
        sweep(0, 4'd4, 4'd6, 4'd1, -1, -1, 1'b0);
        sweep(1, 4'd0, 4'd3, 4'd2, -1, -1, 1'b0);

`ifdef SWEEP_PAUSE_EN
        sweep(0, 4'd2, 4'd4, 4'd1, -1, 1, 1'b0);
        sweep(1, 4'd2, 4'd4, 4'd1, 3, 1, 1'b0);
`endif

        for (int n = 0; n < 16; n++) begin
            d  = int'($urandom_range(1, 0));
            lo = int'($urandom_range(14, 0));
            hi = int'($urandom_range(15, lo + 1));
            ps = int'($urandom_range(3, 0));
            ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(20, 0)) : -1;
            if ($urandom_range(4, 0) == 0) bad_start(d, 4'(hi), 4'(lo));
            sweep(d, 4'(lo), 4'(hi), 4'(ps), ab, -1, ab < 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
